// File: rtl/ternary_matvec_tiled.sv
// Ternary matrix-vector multiply: result = M x v, processing P columns per cycle.
// Operands are captured on accept; the result is presented with a valid/ready handshake.
module ternary_matvec_tiled #(
  parameter int unsigned D        = 16,
  parameter int unsigned W        = 16,
  parameter int unsigned P        = 4,
  parameter bit          SATURATE = 1'b1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [D-1:0][W-1:0]      vector_i,
  input  logic [D-1:0][D-1:0][1:0] matrix_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  output logic [D-1:0][W-1:0]      result_o,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic                     sat_o,
  output logic                     err_o
);

  localparam int unsigned NChunks = D / P;
  localparam int unsigned CntW    = (NChunks > 1) ? $clog2(NChunks) : 1;
  localparam int unsigned IdxW    = (D > 1) ? $clog2(D) : 1;
  // Chunk sum width: P products of W-bit words, plus headroom for negating -2^(W-1).
  localparam int unsigned SW      = W + $clog2(P) + 1;
  localparam logic signed [SW:0] AccMax = {{(SW - W + 2){1'b0}}, {(W - 1){1'b1}}};
  localparam logic signed [SW:0] AccMin = ~AccMax;

  typedef enum logic [1:0] {StIdle, StWork, StDone} state_e;

  state_e                     state_q, state_d;
  logic [CntW-1:0]            cnt_q, cnt_d;
  logic [D-1:0][W-1:0]        vec_q, vec_d;
  logic [D-1:0][D-1:0][1:0]   mat_q, mat_d;
  logic [D-1:0][W-1:0]        acc_q, acc_d;
  logic [D-1:0][W-1:0]        result_q, result_d;
  logic                       sat_q, sat_d;
  logic                       err_q, err_d;

  logic [D-1:0][W-1:0]        chunk_acc;
  logic                       chunk_sat;
  logic                       chunk_err;
  logic                       accept;

  assign in_ready_o  = (state_q == StIdle) | ((state_q == StDone) & out_ready_i);
  assign accept      = in_ready_o & in_valid_i;
  assign out_valid_o = (state_q == StDone);
  assign result_o    = result_q;
  assign sat_o       = sat_q;
  assign err_o       = err_q;

  // Accumulate the current P-column chunk into every row, clamping once per chunk.
  always_comb begin
    logic signed [SW-1:0] sum_s;
    logic signed [SW-1:0] term;
    logic signed [SW:0]   acc_w;
    logic [IdxW-1:0]      col;
    chunk_acc = '0;
    chunk_sat = 1'b0;
    chunk_err = 1'b0;
    sum_s     = '0;
    term      = '0;
    acc_w     = '0;
    col       = '0;
    for (int i = 0; i < D; i++) begin
      sum_s = '0;
      for (int j = 0; j < P; j++) begin
        col  = IdxW'(32'(cnt_q) * P + 32'(j));
        term = SW'($signed(vec_q[col]));
        case (mat_q[i][col])
          2'b01:   sum_s = sum_s + term;
          2'b11:   sum_s = sum_s - term;
          2'b10:   chunk_err = 1'b1;
          default: ;
        endcase
      end
      acc_w = (SW + 1)'($signed(acc_q[i])) + (SW + 1)'(sum_s);
      if (SATURATE && (acc_w > AccMax)) begin
        chunk_acc[i] = AccMax[W-1:0];
        chunk_sat    = 1'b1;
      end else if (SATURATE && (acc_w < AccMin)) begin
        chunk_acc[i] = AccMin[W-1:0];
        chunk_sat    = 1'b1;
      end else begin
        chunk_acc[i] = acc_w[W-1:0];
      end
    end
  end

  // Next-state logic: accept operands, step through chunks, hold result until taken.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    vec_d    = vec_q;
    mat_d    = mat_q;
    acc_d    = acc_q;
    result_d = result_q;
    sat_d    = sat_q;
    err_d    = err_q;
    unique case (state_q)
      StIdle: ;
      StWork: begin
        acc_d = chunk_acc;
        sat_d = sat_q | chunk_sat;
        err_d = err_q | chunk_err;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntW'(NChunks - 1)) begin
          state_d  = StDone;
          result_d = chunk_acc;
          cnt_d    = '0;
        end
      end
      StDone: begin
        if (out_ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    // Accept overrides: covers both IDLE and the zero-bubble DONE handoff.
    if (accept) begin
      state_d = StWork;
      vec_d   = vector_i;
      mat_d   = matrix_i;
      acc_d   = '0;
      sat_d   = 1'b0;
      err_d   = 1'b0;
      cnt_d   = '0;
    end
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      vec_q    <= '0;
      mat_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
      sat_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      vec_q    <= vec_d;
      mat_q    <= mat_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      sat_q    <= sat_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_ternary_matvec_tiled.sv
// Randomised bench for ternary_matvec_tiled: saturating and wrapping instances share stimulus
// and are compared against a plain-arithmetic reference model.
module tb_ternary_matvec_tiled;

  localparam int unsigned D = 16;
  localparam int unsigned W = 16;
  localparam int unsigned P = 4;
  localparam longint SMax = 2 ** (W - 1) - 1;
  localparam longint SMin = -(2 ** (W - 1));

  logic             clk;
  logic             rst_n;
  logic [D*W-1:0]   vec;
  logic [D*D*2-1:0] mat;
  logic             in_valid;
  logic             out_ready;

  logic             in_ready_s, out_valid_s, sat_s, err_s;
  logic [D*W-1:0]   res_s;
  logic             in_ready_w, out_valid_w, sat_w, err_w;
  logic [D*W-1:0]   res_w;

  logic [D*D*2-1:0] m_r;
  logic [D*W-1:0]   v_r;
  logic [D*W-1:0]   exp_res_s, exp_res_w;
  bit               exp_sat_s, exp_sat_w, exp_err;

  int n_checks = 0;
  int n_errors = 0;

  ternary_matvec_tiled #(.D(D), .W(W), .P(P), .SATURATE(1'b1)) u_dut_sat (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .vector_i    (vec),
    .matrix_i    (mat),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready_s),
    .result_o    (res_s),
    .out_valid_o (out_valid_s),
    .out_ready_i (out_ready),
    .sat_o       (sat_s),
    .err_o       (err_s)
  );

  ternary_matvec_tiled #(.D(D), .W(W), .P(P), .SATURATE(1'b0)) u_dut_wrap (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .vector_i    (vec),
    .matrix_i    (mat),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready_w),
    .result_o    (res_w),
    .out_valid_o (out_valid_w),
    .out_ready_i (out_ready),
    .sat_o       (sat_w),
    .err_o       (err_w)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: row sums over column chunks of P, clamp after each chunk if saturating.
  task automatic model(input bit satm, output logic [D*W-1:0] res, output bit sf, output bit ef);
    res = '0;
    sf  = 1'b0;
    ef  = 1'b0;
    for (int i = 0; i < D; i++) begin
      longint acc;
      acc = 0;
      for (int c = 0; c < D; c += P) begin
        longint s;
        s = 0;
        for (int j = c; j < c + P; j++) begin
          logic [1:0]   code;
          logic [W-1:0] word;
          code = m_r[(i*D+j)*2 +: 2];
          word = v_r[j*W +: W];
          if (code == 2'b01) s += longint'($signed(word));
          else if (code == 2'b11) s -= longint'($signed(word));
          else if (code == 2'b10) ef = 1'b1;
        end
        acc += s;
        if (satm && acc > SMax) begin
          acc = SMax;
          sf  = 1'b1;
        end else if (satm && acc < SMin) begin
          acc = SMin;
          sf  = 1'b1;
        end
      end
      res[i*W +: W] = acc[W-1:0];
    end
  endtask

  task automatic compute_expected();
    bit dummy;
    model(1'b1, exp_res_s, exp_sat_s, exp_err);
    model(1'b0, exp_res_w, exp_sat_w, dummy);
    exp_sat_w = 1'b0;
  endtask

  // Present m_r/v_r while the unit is idle; returns #1 after the accepting edge.
  task automatic start_op();
    compute_expected();
    mat      = m_r;
    vec      = v_r;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    mat      = ~m_r;
    vec      = ~v_r;
  endtask

  task automatic wait_check(input string tag);
    int n;
    n = 0;
    while (!out_valid_s && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq({tag, "_lat"}, 256'(n), 256'(D / P));
    check_eq({tag, "_vld_w"}, 256'(out_valid_w), 256'(1));
    check_eq({tag, "_res_s"}, 256'(res_s), 256'(exp_res_s));
    check_eq({tag, "_sat_s"}, 256'(sat_s), 256'(exp_sat_s));
    check_eq({tag, "_err_s"}, 256'(err_s), 256'(exp_err));
    check_eq({tag, "_res_w"}, 256'(res_w), 256'(exp_res_w));
    check_eq({tag, "_sat_w"}, 256'(sat_w), 256'(exp_sat_w));
    check_eq({tag, "_err_w"}, 256'(err_w), 256'(exp_err));
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check_eq("idle_rdy", 256'(in_ready_s), 256'(1));
  endtask

  task automatic fill_matrix(input logic [1:0] code);
    for (int k = 0; k < D * D; k++) m_r[k*2 +: 2] = code;
  endtask

  task automatic random_op(input int mode);
    for (int k = 0; k < D * D; k++) begin
      int r;
      r = $urandom_range(0, 2);
      m_r[k*2 +: 2] = (r == 0) ? 2'b00 : ((r == 1) ? 2'b01 : 2'b11);
      if (mode == 2 && $urandom_range(0, 31) == 0) m_r[k*2 +: 2] = 2'b10;
    end
    for (int k = 0; k < D; k++) begin
      if (mode == 0) v_r[k*W +: W] = W'($urandom_range(0, 400)) - W'(200);
      else v_r[k*W +: W] = W'($urandom);
    end
  endtask

  logic [D*W-1:0] const_exp;

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    vec       = '0;
    mat       = '0;
    m_r       = '0;
    v_r       = '0;
    #12;
    check_eq("rst_rdy", 256'(in_ready_s), 256'(1));
    check_eq("rst_vld", 256'(out_valid_s), 256'(0));
    check_eq("rst_res", 256'(res_s), 256'(0));
    check_eq("rst_sat", 256'(sat_s), 256'(0));
    check_eq("rst_err", 256'(err_s), 256'(0));
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Identity matrix, v[k] = k+1.
    m_r = '0;
    for (int k = 0; k < D; k++) begin
      m_r[(k*D+k)*2 +: 2] = 2'b01;
      v_r[k*W +: W]       = W'(k + 1);
      const_exp[k*W +: W] = W'(k + 1);
    end
    start_op();
    wait_check("ident");
    check_eq("ident_const", 256'(res_s), 256'(const_exp));
    release_result();

    // All +1, large positive values: clamp vs wrap.
    fill_matrix(2'b01);
    for (int k = 0; k < D; k++) v_r[k*W +: W] = 16'h7000;
    start_op();
    wait_check("pos");
    for (int k = 0; k < D; k++) const_exp[k*W +: W] = 16'h7FFF;
    check_eq("pos_const_s", 256'(res_s), 256'(const_exp));
    check_eq("pos_const_w", 256'(res_w), 256'(0));
    check_eq("pos_sat_c", 256'(sat_s), 256'(1));
    release_result();

    // All -1, max positive values: clamp to most negative.
    fill_matrix(2'b11);
    for (int k = 0; k < D; k++) v_r[k*W +: W] = 16'h7FFF;
    start_op();
    wait_check("neg");
    for (int k = 0; k < D; k++) const_exp[k*W +: W] = 16'h8000;
    check_eq("neg_const_s", 256'(res_s), 256'(const_exp));
    release_result();

    // Negating -2^(W-1) must not wrap.
    fill_matrix(2'b00);
    for (int k = 0; k < D; k++) v_r[k*W +: W] = 16'h8000;
    m_r[(0*D+0)*2 +: 2] = 2'b11;
    start_op();
    wait_check("negmin");
    release_result();

    // Illegal code contributes zero and flags err_o.
    fill_matrix(2'b00);
    v_r = '0;
    v_r[0 +: W] = W'(5);
    m_r[0 +: 2] = 2'b10;
    start_op();
    wait_check("illegal");
    check_eq("illegal_res0", 256'(res_s[0 +: W]), 256'(0));
    check_eq("illegal_err_c", 256'(err_s), 256'(1));
    release_result();

    // Random operations; err_o from the previous op must clear on accept.
    for (int t = 0; t < 12; t++) begin
      random_op(t % 3);
      start_op();
      if (t == 0) check_eq("err_clear", 256'(err_s), 256'(0));
      wait_check($sformatf("rnd%0d", t));
      release_result();
    end

    // Backpressure in DONE, then zero-bubble accept.
    random_op(1);
    start_op();
    wait_check("bp");
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      check_eq("bp_vld", 256'(out_valid_s), 256'(1));
      check_eq("bp_rdy", 256'(in_ready_s), 256'(0));
      check_eq("bp_res", 256'(res_s), 256'(exp_res_s));
    end
    random_op(0);
    compute_expected();
    mat       = m_r;
    vec       = v_r;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    check_eq("b2b_rdy", 256'(in_ready_s), 256'(1));
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    mat       = ~m_r;
    vec       = ~v_r;
    check_eq("b2b_work_vld", 256'(out_valid_s), 256'(0));
    check_eq("b2b_work_rdy", 256'(in_ready_s), 256'(0));
    wait_check("b2b");
    release_result();

    // Asynchronous reset while counter == 2.
    random_op(1);
    start_op();
    @(posedge clk);
    #1;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_vld", 256'(out_valid_s), 256'(0));
    check_eq("mid_rst_res", 256'(res_s), 256'(0));
    check_eq("mid_rst_sat", 256'(sat_s), 256'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("post_rst_rdy", 256'(in_ready_s), 256'(1));
    check_eq("post_rst_vld", 256'(out_valid_s), 256'(0));
    random_op(0);
    start_op();
    wait_check("post_rst");
    release_result();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
